// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit types, flit field offsets and port indices.
package noc_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int FLIT_W      = 80;
  localparam int TYPE_LSB    = 0;
  localparam int TYPE_MSB    = 1;
  localparam int NXT_HOP_LSB = 2;
  localparam int NXT_HOP_MSB = 6;
  localparam int DST_X_LSB   = 7;
  localparam int DST_X_MSB   = 8;
  localparam int DST_Y_LSB   = 9;
  localparam int DST_Y_MSB   = 10;
  localparam int VCX_LSB     = 11;
  localparam int VCX_MSB     = 15;
  localparam int DATA_LSB    = 16;
  localparam int DATA_MSB    = 79;

  localparam int PORT_NUM = 5;
  localparam int XP       = 0;
  localparam int XM       = 1;
  localparam int YM       = 2;
  localparam int YP       = 3;
  localparam int LOCAL    = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic found;
  int   pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/out_port_arb.sv
// Per-output wormhole switch arbiter: round-robin head arbitration, head-to-tail
// lock of the output, and downstream credit tracking.
module out_port_arb #(
  parameter int PORT_NUM   = 5,
  parameter int CREDIT_MAX = 4,
  localparam int CW = $clog2(CREDIT_MAX + 1),
  localparam int IW = $clog2(PORT_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] req,
  input  logic [1:0]          flit_type [PORT_NUM],
  input  logic                credit_in,
  output logic [PORT_NUM-1:0] grant,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_vld,
  output logic                locked,
  output logic [IW-1:0]       owner,
  output logic [CW-1:0]       credit_cnt,
  output logic                credit_err
);
  import noc_pkg::*;

  arb_state_e          state;
  logic [IW-1:0]       rr_ptr;
  logic [PORT_NUM-1:0] elig;
  flit_type_e          win_type;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(PORT_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  // While locked only the owner may compete, so the picker simply returns it.
  always_comb begin
    elig = '0;
    if (!rst && credit_cnt != '0) begin
      if (state == IDLE) begin
        for (int i = 0; i < PORT_NUM; i++)
          elig[i] = req[i] && (flit_type[i] == HEAD || flit_type[i] == HEAD_TAIL);
      end else begin
        elig[owner] = req[owner];
      end
    end
  end

  rr_pick #(.N(PORT_NUM)) u_pick (
    .req    (elig),
    .ptr    (rr_ptr),
    .onehot (grant),
    .idx    (grant_idx)
  );

  assign grant_vld = |grant;
  assign win_type  = flit_type_e'(flit_type[grant_idx]);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            if (win_type == HEAD) begin
              state <= LOCKED;
              owner <= grant_idx;
            end else begin
              rr_ptr <= ptr_inc(grant_idx);
            end
          end
        end
        LOCKED: begin
          if (grant_vld && (win_type == TAIL || win_type == HEAD_TAIL)) begin
            state  <= IDLE;
            rr_ptr <= ptr_inc(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A returned credit while already full means downstream miscounted; flag it for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CW'(CREDIT_MAX);
      credit_err <= 1'b0;
    end else begin
      case ({grant_vld, credit_in})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: begin
          if (credit_cnt == CW'(CREDIT_MAX))
            credit_err <= 1'b1;
          else
            credit_cnt <= credit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arb.sv
// Directed self-checking bench for out_port_arb with hand-computed expectations.
module tb_out_port_arb;
  import noc_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [1:0] ft [5];
  logic       credit_in;
  logic [4:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       locked;
  logic [2:0] owner;
  logic [2:0] credit_cnt;
  logic       credit_err;

  int errors = 0;
  int checks = 0;

  out_port_arb #(.PORT_NUM(5), .CREDIT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flit_type  (ft),
    .credit_in  (credit_in),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld),
    .locked     (locked),
    .owner      (owner),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    credit_in = 1'b0;
    for (int i = 0; i < 5; i++) ft[i] = HEAD;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    credit_in = 1'b0;
    req = 5'b11111;
    for (int i = 0; i < 5; i++) ft[i] = HEAD;
    cyc();
    cyc();
    checks++; if (grant !== 5'b00000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 00000", grant); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("[TB] FAIL reset_credit: got %0d expected 4", credit_cnt); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", credit_err); end
    rst = 1'b0;
    req = '0;
    #1;
    checks++; if (grant_idx !== 3'd0 || grant_vld !== 1'b0) begin errors++; $display("[TB] FAIL idle_idx: got idx %0d vld %b expected 0 0", grant_idx, grant_vld); end
  endtask

  task automatic test_lock_packet();
    flit_type_e seq [3] = '{BODY, BODY, TAIL};
    do_reset();
    req = 5'b00101; ft[0] = HEAD; ft[2] = HEAD;
    #1;
    checks++; if (grant !== 5'b00001 || grant_idx !== 3'd0 || grant_vld !== 1'b1) begin errors++; $display("[TB] FAIL head_grant: got %b idx %0d expected 00001 idx 0", grant, grant_idx); end
    cyc();
    checks++; if (locked !== 1'b1 || owner !== 3'd0) begin errors++; $display("[TB] FAIL head_lock: got locked %b owner %0d expected 1 0", locked, owner); end
    checks++; if (credit_cnt !== 3'd3) begin errors++; $display("[TB] FAIL head_credit: got %0d expected 3", credit_cnt); end
    for (int k = 0; k < 3; k++) begin
      ft[0] = seq[k];
      credit_in = 1'b1;
      #1;
      checks++; if (grant !== 5'b00001) begin errors++; $display("[TB] FAIL pkt_flit%0d: got %b expected 00001", k, grant); end
      cyc();
    end
    credit_in = 1'b0;
    checks++; if (locked !== 1'b0 || credit_cnt !== 3'd3) begin errors++; $display("[TB] FAIL tail_unlock: got locked %b cnt %0d expected 0 3", locked, credit_cnt); end
    ft[0] = HEAD;
    #1;
    checks++; if (grant !== 5'b00100 || grant_idx !== 3'd2) begin errors++; $display("[TB] FAIL rr_next_head: got %b idx %0d expected 00100 idx 2", grant, grant_idx); end
    cyc();
    checks++; if (locked !== 1'b1 || owner !== 3'd2 || credit_cnt !== 3'd2) begin errors++; $display("[TB] FAIL lock2: got locked %b owner %0d cnt %0d expected 1 2 2", locked, owner, credit_cnt); end
    req = 5'b00100; ft[2] = TAIL;
    #1;
    checks++; if (grant !== 5'b00100) begin errors++; $display("[TB] FAIL tail2: got %b expected 00100", grant); end
    cyc();
    checks++; if (locked !== 1'b0 || credit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL tail2_unlock: got locked %b cnt %0d expected 0 1", locked, credit_cnt); end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp;
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 5; i++) ft[i] = HEAD_TAIL;
    credit_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp = 5'b00001 << (k % 5);
      #1;
      checks++; if (grant !== exp || locked !== 1'b0) begin errors++; $display("[TB] FAIL rr_%0d: got %b locked %b expected %b 0", k, grant, locked, exp); end
      cyc();
    end
    clear_inputs();
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("[TB] FAIL rr_credit: got %0d expected 4", credit_cnt); end
  endtask

  task automatic test_credit_exhaust();
    flit_type_e seq [4] = '{HEAD, BODY, BODY, BODY};
    do_reset();
    req = 5'b01000;
    for (int k = 0; k < 4; k++) begin
      ft[3] = seq[k];
      #1;
      checks++; if (grant !== 5'b01000) begin errors++; $display("[TB] FAIL cx_grant%0d: got %b expected 01000", k, grant); end
      cyc();
    end
    ft[3] = BODY;
    #1;
    checks++; if (credit_cnt !== 3'd0 || grant !== 5'b00000 || grant_vld !== 1'b0) begin errors++; $display("[TB] FAIL cx_empty: got cnt %0d grant %b expected 0 00000", credit_cnt, grant); end
    checks++; if (locked !== 1'b1 || owner !== 3'd3) begin errors++; $display("[TB] FAIL cx_locked: got locked %b owner %0d expected 1 3", locked, owner); end
    credit_in = 1'b1;
    cyc();
    credit_in = 1'b0;
    #1;
    checks++; if (credit_cnt !== 3'd1 || grant !== 5'b01000) begin errors++; $display("[TB] FAIL cx_refill: got cnt %0d grant %b expected 1 01000", credit_cnt, grant); end
    cyc();
    ft[3] = TAIL;
    credit_in = 1'b1;
    cyc();
    credit_in = 1'b0;
    #1;
    checks++; if (grant !== 5'b01000) begin errors++; $display("[TB] FAIL cx_tail: got %b expected 01000", grant); end
    cyc();
    req = '0;
    checks++; if (locked !== 1'b0 || credit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL cx_done: got locked %b cnt %0d expected 0 0", locked, credit_cnt); end
  endtask

  task automatic test_credit_simul();
    credit_in = 1'b1;
    cyc();
    cyc();
    credit_in = 1'b0;
    checks++; if (credit_cnt !== 3'd2) begin errors++; $display("[TB] FAIL sim_pre: got %0d expected 2", credit_cnt); end
    req = 5'b00010; ft[1] = HEAD_TAIL; credit_in = 1'b1;
    #1;
    checks++; if (grant !== 5'b00010) begin errors++; $display("[TB] FAIL sim_grant: got %b expected 00010", grant); end
    cyc();
    req = '0;
    checks++; if (credit_cnt !== 3'd2) begin errors++; $display("[TB] FAIL sim_hold: got %0d expected 2", credit_cnt); end
    cyc();
    cyc();
    checks++; if (credit_cnt !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("[TB] FAIL sim_full: got cnt %0d err %b expected 4 0", credit_cnt, credit_err); end
    cyc();
    credit_in = 1'b0;
    checks++; if (credit_cnt !== 3'd4 || credit_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow: got cnt %0d err %b expected 4 1", credit_cnt, credit_err); end
    req = 5'b00001; ft[0] = HEAD_TAIL;
    cyc();
    req = '0;
    cyc();
    checks++; if (credit_cnt !== 3'd3 || credit_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got cnt %0d err %b expected 3 1", credit_cnt, credit_err); end
  endtask

  task automatic test_blocking();
    do_reset();
    checks++; if (credit_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", credit_err); end
    req = 5'b00010; ft[1] = BODY;
    #1;
    checks++; if (grant !== 5'b00000) begin errors++; $display("[TB] FAIL idle_body: got %b expected 00000", grant); end
    cyc();
    ft[1] = TAIL;
    #1;
    checks++; if (grant !== 5'b00000 || locked !== 1'b0) begin errors++; $display("[TB] FAIL idle_tail: got %b locked %b expected 00000 0", grant, locked); end
    req = 5'b10000; ft[4] = HEAD;
    #1;
    checks++; if (grant !== 5'b10000) begin errors++; $display("[TB] FAIL blk_head4: got %b expected 10000", grant); end
    cyc();
    req = 5'b10001; ft[0] = HEAD; ft[4] = BODY;
    #1;
    checks++; if (grant !== 5'b10000 || owner !== 3'd4) begin errors++; $display("[TB] FAIL blk_body4: got %b owner %0d expected 10000 4", grant, owner); end
    cyc();
    req = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (grant !== 5'b00000 || locked !== 1'b1) begin errors++; $display("[TB] FAIL bubble%0d: got %b locked %b expected 00000 1", k, grant, locked); end
      cyc();
    end
    req = 5'b10001; ft[4] = TAIL;
    #1;
    checks++; if (grant !== 5'b10000) begin errors++; $display("[TB] FAIL blk_tail4: got %b expected 10000", grant); end
    cyc();
    req = 5'b00001;
    #1;
    checks++; if (locked !== 1'b0 || grant !== 5'b00001 || credit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL blk_release: got locked %b grant %b cnt %0d expected 0 00001 1", locked, grant, credit_cnt); end
    cyc();
    req = '0;
    checks++; if (locked !== 1'b1 || owner !== 3'd0 || credit_cnt !== 3'd0) begin errors++; $display("[TB] FAIL blk_lock0: got locked %b owner %0d cnt %0d expected 1 0 0", locked, owner, credit_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b00100; ft[2] = HEAD_TAIL;
    cyc();
    req = 5'b01000; ft[3] = HEAD;
    cyc();
    ft[3] = BODY;
    cyc();
    checks++; if (locked !== 1'b1 || owner !== 3'd3 || credit_cnt !== 3'd1) begin errors++; $display("[TB] FAIL mid_pre: got locked %b owner %0d cnt %0d expected 1 3 1", locked, owner, credit_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (grant !== 5'b00000) begin errors++; $display("[TB] FAIL mid_rst_grant: got %b expected 00000", grant); end
    cyc();
    rst = 1'b0;
    req = '0;
    checks++; if (locked !== 1'b0 || credit_cnt !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_post: got locked %b cnt %0d err %b expected 0 4 0", locked, credit_cnt, credit_err); end
    req = 5'b11111;
    for (int i = 0; i < 5; i++) ft[i] = HEAD_TAIL;
    #1;
    checks++; if (grant !== 5'b00001) begin errors++; $display("[TB] FAIL mid_rrptr: got %b expected 00001", grant); end
    cyc();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_lock_packet();
    test_round_robin();
    test_credit_exhaust();
    test_credit_simul();
    test_blocking();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
